// File: rtl/axis_merger_rr_2_if.sv
// Handshake bundle for the two-input round-robin AXI-Stream merger.
// The slave view belongs to the merger; the master view drives it.
interface axis_merger_rr_2_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  input_0_valid;
  logic [DATA_WIDTH-1:0] input_0_data;
  logic                  input_0_last;
  logic                  input_0_ready;
  logic                  input_1_valid;
  logic [DATA_WIDTH-1:0] input_1_data;
  logic                  input_1_last;
  logic                  input_1_ready;
  logic                  output_valid;
  logic [DATA_WIDTH-1:0] output_data;
  logic                  output_last;
  logic                  output_source;
  logic                  output_ready;

  modport slave (
    input  input_0_valid, input_0_data, input_0_last,
    output input_0_ready,
    input  input_1_valid, input_1_data, input_1_last,
    output input_1_ready,
    output output_valid, output_data, output_last, output_source,
    input  output_ready
  );

  modport master (
    output input_0_valid, input_0_data, input_0_last,
    input  input_0_ready,
    output input_1_valid, input_1_data, input_1_last,
    input  input_1_ready,
    input  output_valid, output_data, output_last, output_source,
    output output_ready
  );
endinterface

// File: rtl/axis_merger_rr_2.sv
// Two-input round-robin AXI-Stream merger with packet-aware grant locking
// and a single registered output stage.
module axis_merger_rr_2 #(
  parameter int DATA_WIDTH  = 16,
  parameter int PACKET_MODE = 1,
  parameter int START_WITH  = 0
) (
  input logic              clk,
  input logic              rst,
  axis_merger_rr_2_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOCK_0 = 2'd1;
  localparam logic [1:0] LOCK_1 = 2'd2;

  logic [1:0]            state_reg, state_next;
  logic                  ptr_reg, ptr_next;

  logic [1:0]            in_valid;
  logic [1:0]            in_last;
  logic [1:0]            in_ready;
  logic [DATA_WIDTH-1:0] in_data [2];

  logic                  grant_valid;
  logic                  grant_idx;
  logic                  slot_free;
  logic                  accept;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic                  out_last_reg;
  logic                  out_source_reg;

  // Gather both inputs into indexable form so the grant can select by index.
  assign in_valid[0] = bus.input_0_valid;
  assign in_valid[1] = bus.input_1_valid;
  assign in_last[0]  = bus.input_0_last;
  assign in_last[1]  = bus.input_1_last;
  assign in_data[0]  = bus.input_0_data;
  assign in_data[1]  = bus.input_1_data;

  assign bus.input_0_ready = in_ready[0];
  assign bus.input_1_ready = in_ready[1];

  // The output register can take a beat when it is empty or draining this cycle.
  assign slot_free = !out_valid_reg || bus.output_ready;

  // Grant selection: locked states ignore the other input; IDLE uses the pointer on contention.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    case (state_reg)
      LOCK_0: begin
        grant_valid = 1'b1;
        grant_idx   = 1'b0;
      end
      LOCK_1: begin
        grant_valid = 1'b1;
        grant_idx   = 1'b1;
      end
      default: begin
        if (in_valid[0] && in_valid[1]) begin
          grant_valid = 1'b1;
          grant_idx   = ptr_reg;
        end else if (in_valid[0]) begin
          grant_valid = 1'b1;
          grant_idx   = 1'b0;
        end else if (in_valid[1]) begin
          grant_valid = 1'b1;
          grant_idx   = 1'b1;
        end
      end
    endcase
  end

  // Ready depends on grant state, never on the granted input's own valid in lock states.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign in_ready[gi] = grant_valid && (grant_idx == 1'(gi)) && slot_free && !rst;
  end

  assign accept   = in_valid[grant_idx] && in_ready[grant_idx];
  assign sel_data = in_data[grant_idx];
  assign sel_last = in_last[grant_idx];

  // Arbitration FSM: lock onto a packet until its last beat, then hand priority over.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    if (state_reg != IDLE && state_reg != LOCK_0 && state_reg != LOCK_1) begin
      state_next = IDLE;
    end
    if (accept) begin
      if (sel_last || (PACKET_MODE == 0)) begin
        state_next = IDLE;
        ptr_next   = !grant_idx;
      end else begin
        state_next = grant_idx ? LOCK_1 : LOCK_0;
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 1'(START_WITH);
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Output stage: load on accept, empty when drained with nothing new, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_last_reg   <= 1'b0;
      out_source_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg  <= 1'b1;
      out_data_reg   <= sel_data;
      out_last_reg   <= sel_last;
      out_source_reg <= grant_idx;
    end else if (bus.output_ready) begin
      out_valid_reg  <= 1'b0;
    end
  end

  assign bus.output_valid  = out_valid_reg;
  assign bus.output_data   = out_data_reg;
  assign bus.output_last   = out_last_reg;
  assign bus.output_source = out_source_reg;

endmodule

// File: tb/tb_axis_merger_rr_2.sv
// Directed bench for axis_merger_rr_2: reset, alternation, packet locking,
// single-source flow, downstream stall and reset during a locked packet.
module tb_axis_merger_rr_2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  axis_merger_rr_2_if #(.DATA_WIDTH(16)) bus ();

  axis_merger_rr_2 #(
    .DATA_WIDTH (16),
    .PACKET_MODE(1),
    .START_WITH (0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source queues hold {last, data}; output records hold {source, last, data}.
  logic [16:0] q0 [$];
  logic [16:0] q1 [$];
  logic [17:0] exp_q [$];
  logic [17:0] out_q [$];
  int          first_out;
  int          last_out;
  int          ready1_early;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drive queued beats cycle by cycle, collect output beats, optionally stall downstream.
  task automatic run(input int max_cycles, input int start1, input int stall_from, input int stall_len);
    bit          done;
    bit          a0;
    bit          a1;
    bit          last0_seen;
    bit          in_stall;
    logic [15:0] snap;
    done         = 0;
    last0_seen   = 0;
    snap         = '0;
    first_out    = -1;
    last_out     = -1;
    ready1_early = 0;
    out_q.delete();
    for (int k = 0; k < max_cycles; k++) begin
      bus.input_0_valid = (q0.size() > 0);
      bus.input_0_data  = (q0.size() > 0) ? q0[0][15:0] : 16'h0;
      bus.input_0_last  = (q0.size() > 0) ? q0[0][16] : 1'b0;
      bus.input_1_valid = (q1.size() > 0) && (k >= start1);
      bus.input_1_data  = (q1.size() > 0) ? q1[0][15:0] : 16'h0;
      bus.input_1_last  = (q1.size() > 0) ? q1[0][16] : 1'b0;
      in_stall          = (k >= stall_from) && (k < stall_from + stall_len);
      bus.output_ready  = !in_stall;
      #3;
      a0 = bus.input_0_valid && bus.input_0_ready;
      a1 = bus.input_1_valid && bus.input_1_ready;
      if (bus.output_valid && bus.output_ready) begin
        out_q.push_back({bus.output_source, bus.output_last, bus.output_data});
        if (first_out < 0) first_out = k;
        last_out = k;
      end
      if (!last0_seen && bus.input_1_ready) ready1_early++;
      if (a0 && q0[0][16]) last0_seen = 1;
      if (k == stall_from) snap = bus.output_data;
      if (in_stall) begin
        check("stall_valid", bus.output_valid, 1);
        check("stall_data", bus.output_data, snap);
        check("stall_ready0", bus.input_0_ready, 0);
        check("stall_ready1", bus.input_1_ready, 0);
      end
      @(posedge clk);
      #1;
      if (a0) void'(q0.pop_front());
      if (a1) void'(q1.pop_front());
      if (q0.size() == 0 && q1.size() == 0 && !bus.output_valid) begin
        done = 1;
        break;
      end
    end
    if (!done) check("run_timeout", 0, 1);
    bus.input_0_valid = 1'b0;
    bus.input_1_valid = 1'b0;
    bus.output_ready  = 1'b1;
  endtask

  // Compare the collected output beats against the hand-written expectation list.
  task automatic compare_out(input string tag);
    check($sformatf("%s_count", tag), out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < out_q.size()) begin
        $display("%s beat %0d: src=%0d last=%0d data=0x%04h", tag, i,
                 out_q[i][17], out_q[i][16], out_q[i][15:0]);
        check($sformatf("%s_beat%0d", tag, i), out_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;

    // Reset with both inputs presenting beats.
    rst               = 1'b1;
    bus.input_0_valid = 1'b1;
    bus.input_0_data  = 16'h1111;
    bus.input_0_last  = 1'b1;
    bus.input_1_valid = 1'b1;
    bus.input_1_data  = 16'h2222;
    bus.input_1_last  = 1'b1;
    bus.output_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready0", bus.input_0_ready, 0);
    check("rst_ready1", bus.input_1_ready, 0);
    check("rst_valid", bus.output_valid, 0);
    check("rst_data", bus.output_data, 0);
    check("rst_last", bus.output_last, 0);
    check("rst_source", bus.output_source, 0);
    rst               = 1'b0;
    bus.input_0_valid = 1'b0;
    bus.input_1_valid = 1'b0;
    @(posedge clk);
    #1;

    // Single-beat packets from both sides alternate starting at input 0.
    for (int i = 0; i < 4; i++) begin
      q0.push_back({1'b1, 16'h000A + 16'(i)});
      q1.push_back({1'b1, 16'h00B0 + 16'(i)});
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b0, 1'b1, 16'h000A + 16'(i)});
      exp_q.push_back({1'b1, 1'b1, 16'h00B0 + 16'(i)});
    end
    run(40, 0, 1000, 0);
    compare_out("alt");
    check("alt_first_cycle", first_out, 1);
    check("alt_last_cycle", last_out, 8);

    // Four-beat packet on input 0 locks out input 1 until its last beat.
    q0.push_back({1'b0, 16'h0100});
    q0.push_back({1'b0, 16'h0101});
    q0.push_back({1'b0, 16'h0102});
    q0.push_back({1'b1, 16'h0103});
    q1.push_back({1'b0, 16'h0200});
    q1.push_back({1'b1, 16'h0201});
    exp_q.push_back({1'b0, 1'b0, 16'h0100});
    exp_q.push_back({1'b0, 1'b0, 16'h0101});
    exp_q.push_back({1'b0, 1'b0, 16'h0102});
    exp_q.push_back({1'b0, 1'b1, 16'h0103});
    exp_q.push_back({1'b1, 1'b0, 16'h0200});
    exp_q.push_back({1'b1, 1'b1, 16'h0201});
    run(40, 1, 1000, 0);
    compare_out("lock");
    check("lock_ready1_early", ready1_early, 0);
    check("lock_last_cycle", last_out, 6);

    // Only input 1 active while the pointer favours input 0.
    q1.push_back({1'b0, 16'h0300});
    q1.push_back({1'b0, 16'h0301});
    q1.push_back({1'b1, 16'h0302});
    exp_q.push_back({1'b1, 1'b0, 16'h0300});
    exp_q.push_back({1'b1, 1'b0, 16'h0301});
    exp_q.push_back({1'b1, 1'b1, 16'h0302});
    run(40, 0, 1000, 0);
    compare_out("only1");
    check("only1_first_cycle", first_out, 1);

    // Downstream stall of five cycles in the middle of an alternating stream.
    for (int i = 0; i < 4; i++) begin
      q0.push_back({1'b1, 16'h0400 + 16'(i)});
      q1.push_back({1'b1, 16'h0500 + 16'(i)});
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b0, 1'b1, 16'h0400 + 16'(i)});
      exp_q.push_back({1'b1, 1'b1, 16'h0500 + 16'(i)});
    end
    run(60, 0, 3, 5);
    compare_out("stall");
    check("stall_last_cycle", last_out, 13);

    // Reset while locked on input 1, after input 0 moved the pointer to 1.
    bus.output_ready  = 1'b1;
    bus.input_0_valid = 1'b1;
    bus.input_0_data  = 16'h06F0;
    bus.input_0_last  = 1'b1;
    bus.input_1_valid = 1'b0;
    #1;
    check("rl_ready0_c0", bus.input_0_ready, 1);
    @(posedge clk);
    #1;
    bus.input_0_valid = 1'b0;
    bus.input_1_valid = 1'b1;
    bus.input_1_data  = 16'h0600;
    bus.input_1_last  = 1'b0;
    #1;
    check("rl_ready1_c1", bus.input_1_ready, 1);
    @(posedge clk);
    #1;
    bus.input_0_valid = 1'b1;
    bus.input_0_data  = 16'h0700;
    bus.input_0_last  = 1'b1;
    bus.input_1_data  = 16'h0601;
    bus.input_1_last  = 1'b0;
    #1;
    check("rl_locked_ready0", bus.input_0_ready, 0);
    check("rl_locked_ready1", bus.input_1_ready, 1);
    check("rl_locked_data", bus.output_data, 16'h0600);
    rst = 1'b1;
    #1;
    check("rl_rst_ready1", bus.input_1_ready, 0);
    @(posedge clk);
    #1;
    rst               = 1'b0;
    bus.input_1_data  = 16'h0602;
    bus.input_1_last  = 1'b1;
    #1;
    check("rl_after_valid", bus.output_valid, 0);
    check("rl_after_data", bus.output_data, 0);
    check("rl_after_ready0", bus.input_0_ready, 1);
    check("rl_after_ready1", bus.input_1_ready, 0);
    @(posedge clk);
    #1;
    bus.input_0_valid = 1'b0;
    bus.input_1_valid = 1'b0;
    check("rl_out_valid", bus.output_valid, 1);
    check("rl_out_data", bus.output_data, 16'h0700);
    check("rl_out_source", bus.output_source, 0);
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
